// File: rtl/fmt_receiver.sv
// Receiving end of the formatter packet interface: grants packets against free
// FIFO space, checks start/end framing and drains buffered words to a consumer.
module fmt_receiver #(
   parameter int DEPTH = 32,
   parameter int CNT_W = 16
) (
   input  logic                 clk_i,
   input  logic                 rstn_i,
   input  logic                 fmt_req_i,
   input  logic [1:0]           fmt_chid_i,
   input  logic [5:0]           fmt_length_i,
   output logic                 fmt_grant_o,
   input  logic [31:0]          fmt_data_i,
   input  logic                 fmt_start_i,
   input  logic                 fmt_end_i,
   output logic                 rx_val_o,
   input  logic                 rx_rdy_i,
   output logic [31:0]          rx_data_o,
   output logic [1:0]           rx_chid_o,
   output logic                 rx_last_o,
   output logic [4*CNT_W-1:0]   pkt_cnt_o,
   output logic                 err_o,
   output logic [2:0]           err_code_o,
   input  logic                 err_clr_i
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {IDLE, GRANT, RECV} state_e;

   typedef struct packed {
      logic [1:0]  chid;
      logic        last;
      logic [31:0] data;
   } entry_t;

   state_e             state_q, state_d;
   logic [1:0]         chid_q, chid_d;
   logic [5:0]         len_q, len_d;
   logic [5:0]         beat_q, beat_d;
   logic               pkt_err_q, pkt_err_d;
   logic               illeg_q, illeg_d;
   logic               err_q, err_d;
   logic [2:0]         code_q, code_d;
   logic [CNT_W-1:0]   cnt_q [4];
   logic [CNT_W-1:0]   cnt_d [4];
   logic [6:0]         count_q, count_d;
   logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
   entry_t             mem_q [DEPTH];

   logic       len_ok, req_legal, req_illegal;
   logic       in_recv, first_beat, last_beat;
   logic       start_err, end_err, push, pop;
   logic [6:0] free;
   entry_t     head;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   assign free        = 7'(DEPTH) - count_q;
   assign len_ok      = (fmt_length_i != 6'd0) && ({1'b0, fmt_length_i} <= 7'(DEPTH));
   assign req_legal   = (state_q == IDLE) && fmt_req_i && len_ok && ({1'b0, fmt_length_i} <= free);
   assign req_illegal = (state_q == IDLE) && fmt_req_i && !len_ok;
   assign in_recv     = (state_q == RECV);
   assign first_beat  = (beat_q == 6'd0);
   assign last_beat   = (beat_q == len_q - 6'd1);
   assign start_err   = in_recv && (fmt_start_i != first_beat);
   assign end_err     = in_recv && (fmt_end_i != last_beat);
   assign push        = in_recv;
   assign pop         = rx_val_o && rx_rdy_i;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (req_legal) state_d = GRANT;
         GRANT:   state_d = RECV;
         RECV:    if (last_beat) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      fmt_grant_o = (state_q == GRANT);
   end

   always_comb begin
      chid_d    = chid_q;
      len_d     = len_q;
      cnt_d     = cnt_q;
      wr_ptr_d  = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d  = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      beat_d    = in_recv ? beat_q + 6'd1 : 6'd0;
      pkt_err_d = in_recv && !last_beat && (pkt_err_q || start_err || end_err);
      illeg_d   = req_illegal;
      err_d     = start_err || end_err || (req_illegal && !illeg_q);
      // A new error in the same cycle as a clear still lands in the status.
      code_d    = (err_clr_i ? 3'b000 : code_q) | {req_illegal, end_err, start_err};
      if (req_legal) begin
         chid_d = fmt_chid_i;
         len_d  = fmt_length_i;
      end
      if (in_recv && last_beat && !(pkt_err_q || start_err || end_err))
         cnt_d[chid_q] = cnt_q[chid_q] + CNT_W'(1);
      unique case ({push, pop})
         2'b10:   count_d = count_q + 7'd1;
         2'b01:   count_d = count_q - 7'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         chid_q    <= '0;
         len_q     <= '0;
         beat_q    <= '0;
         pkt_err_q <= 1'b0;
         illeg_q   <= 1'b0;
         err_q     <= 1'b0;
         code_q    <= '0;
         cnt_q     <= '{default: '0};
         count_q   <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
      end else begin
         chid_q    <= chid_d;
         len_q     <= len_d;
         beat_q    <= beat_d;
         pkt_err_q <= pkt_err_d;
         illeg_q   <= illeg_d;
         err_q     <= err_d;
         code_q    <= code_d;
         cnt_q     <= cnt_d;
         count_q   <= count_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
      end
   end

   // NOTE: storage is not reset; the count alone decides which entries are valid.
   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q] <= '{chid: chid_q, last: last_beat, data: fmt_data_i};
   end

   assign head       = mem_q[rd_ptr_q];
   assign rx_val_o   = (count_q != 7'd0);
   assign rx_data_o  = rx_val_o ? head.data : 32'd0;
   assign rx_chid_o  = rx_val_o ? head.chid : 2'd0;
   assign rx_last_o  = rx_val_o && head.last;
   assign err_o      = err_q;
   assign err_code_o = code_q;

   for (genvar g = 0; g < 4; g++) begin : g_cnt
      assign pkt_cnt_o[g*CNT_W +: CNT_W] = cnt_q[g];
   end

endmodule

// File: tb/tb_fmt_receiver.sv
// Directed-plus-random bench for fmt_receiver; a word queue and per-channel
// counters model what the consumer side must observe.
module tb_fmt_receiver;

   localparam int DEPTH = 32;
   localparam int CNT_W = 16;

   logic                clk_i = 1'b0;
   logic                rstn_i;
   logic                fmt_req_i;
   logic [1:0]          fmt_chid_i;
   logic [5:0]          fmt_length_i;
   logic                fmt_grant_o;
   logic [31:0]         fmt_data_i;
   logic                fmt_start_i;
   logic                fmt_end_i;
   logic                rx_val_o;
   logic                rx_rdy_i;
   logic [31:0]         rx_data_o;
   logic [1:0]          rx_chid_o;
   logic                rx_last_o;
   logic [4*CNT_W-1:0]  pkt_cnt_o;
   logic                err_o;
   logic [2:0]          err_code_o;
   logic                err_clr_i;

   fmt_receiver #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk_i(clk_i), .rstn_i(rstn_i),
      .fmt_req_i(fmt_req_i), .fmt_chid_i(fmt_chid_i), .fmt_length_i(fmt_length_i),
      .fmt_grant_o(fmt_grant_o), .fmt_data_i(fmt_data_i),
      .fmt_start_i(fmt_start_i), .fmt_end_i(fmt_end_i),
      .rx_val_o(rx_val_o), .rx_rdy_i(rx_rdy_i), .rx_data_o(rx_data_o),
      .rx_chid_o(rx_chid_o), .rx_last_o(rx_last_o), .pkt_cnt_o(pkt_cnt_o),
      .err_o(err_o), .err_code_o(err_code_o), .err_clr_i(err_clr_i)
   );

   always #5 clk_i = ~clk_i;

   int               n_checks = 0;
   int               n_fail = 0;
   int               cyc = 0;
   int               last_grant_cyc = 0;
   bit               rand_rdy = 1'b0;
   logic [34:0]      exp_q [$];
   logic [CNT_W-1:0] exp_cnt [4];
   logic [2:0]       exp_code;

   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Consumer-side scoreboard: every accepted word must match the model head.
   always @(negedge clk_i) begin
      logic [34:0] w;
      if (rstn_i && rx_val_o && rx_rdy_i) begin
         if (exp_q.size() == 0) check("rx_unexpected", 64'(rx_val_o), 64'(0));
         else begin
            w = exp_q.pop_front();
            check("rx_word", 64'({rx_chid_o, rx_last_o, rx_data_o}), 64'(w));
         end
      end
   end

   task automatic step();
      @(posedge clk_i);
      #1;
      if (rand_rdy) rx_rdy_i = 1'($urandom_range(0, 1));
   endtask

   task automatic wait_grant(output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (!fmt_grant_o && n < 400);
      check("grant_seen", 64'(fmt_grant_o), 64'(1));
      last_grant_cyc = cyc;
      fmt_req_i = 1'b0;
   endtask

   task automatic send_beats(input logic [1:0] ch, input int len, input logic [63:0] bad_s,
                             input logic [63:0] bad_e, input bit chk_head);
      logic [31:0] d;
      bit          bad;
      bit          pkt_bad = 1'b0;
      step();
      check("grant_pulse", 64'(fmt_grant_o), 64'(0));
      for (int k = 0; k < len; k++) begin
         d   = $urandom;
         bad = bad_s[k] | bad_e[k];
         check("no_push_full", 64'(exp_q.size() < DEPTH), 64'(1));
         fmt_data_i  = d;
         fmt_start_i = (k == 0) ^ bad_s[k];
         fmt_end_i   = (k == len - 1) ^ bad_e[k];
         exp_q.push_back({ch, k == len - 1, d});
         if (bad_s[k]) exp_code[0] = 1'b1;
         if (bad_e[k]) exp_code[1] = 1'b1;
         pkt_bad |= bad;
         step();
         check("err_pulse", 64'(err_o), 64'(bad));
         check("rx_val_lat", 64'(rx_val_o), 64'(1));
         if (chk_head) check("rx_head", 64'(rx_data_o), 64'(d));
      end
      fmt_start_i = 1'b0;
      fmt_end_i   = 1'b0;
      if (!pkt_bad) exp_cnt[ch] = exp_cnt[ch] + CNT_W'(1);
   endtask

   task automatic send_pkt(input logic [1:0] ch, input int len, input logic [63:0] bad_s,
                           input logic [63:0] bad_e, input int exp_wait, input bit chk_head);
      int n;
      fmt_req_i    = 1'b1;
      fmt_chid_i   = ch;
      fmt_length_i = 6'(len);
      wait_grant(n);
      if (exp_wait > 0) check("grant_latency", 64'(n), 64'(exp_wait));
      send_beats(ch, len, bad_s, bad_e, chk_head);
   endtask

   task automatic drain();
      int b = 0;
      while (exp_q.size() != 0 && b < 600) begin
         step();
         b++;
      end
      check("drain_done", 64'(exp_q.size()), 64'(0));
      step();
      check("empty_after_drain", 64'(rx_val_o), 64'(0));
   endtask

   task automatic check_status();
      for (int c = 0; c < 4; c++)
         check("pkt_cnt", 64'(pkt_cnt_o[c*CNT_W +: CNT_W]), 64'(exp_cnt[c]));
      check("err_code", 64'(err_code_o), 64'(exp_code));
   endtask

   initial begin
      int n;
      int g_prev;
      rstn_i = 1'b0; fmt_req_i = 1'b0; fmt_chid_i = '0; fmt_length_i = '0;
      fmt_data_i = '0; fmt_start_i = 1'b0; fmt_end_i = 1'b0;
      rx_rdy_i = 1'b0; err_clr_i = 1'b0;
      exp_cnt = '{default: '0};
      exp_code = '0;

      // Reset state
      #12;
      check("rst_grant", 64'(fmt_grant_o), 64'(0));
      check("rst_val", 64'(rx_val_o), 64'(0));
      check("rst_data", 64'({rx_chid_o, rx_last_o, rx_data_o}), 64'(0));
      check("rst_err", 64'(err_o), 64'(0));
      check_status();
      @(posedge clk_i); #1;
      rstn_i = 1'b1;
      step();

      // Single legal packet
      rx_rdy_i = 1'b1;
      send_pkt(2'd2, 4, 64'h0, 64'h0, 1, 1'b1);
      drain();
      check_status();

      // Backpressure: fill to DEPTH, third request must wait for space
      rx_rdy_i = 1'b0;
      send_pkt(2'd0, 16, 64'h0, 64'h0, 1, 1'b0);
      send_pkt(2'd1, 16, 64'h0, 64'h0, 1, 1'b0);
      fmt_req_i = 1'b1; fmt_chid_i = 2'd3; fmt_length_i = 6'd8;
      for (int i = 0; i < 5; i++) begin
         step();
         check("bp_no_grant", 64'(fmt_grant_o), 64'(0));
         check("bp_no_err", 64'(err_o), 64'(0));
      end
      check("bp_head", 64'(rx_data_o), 64'(exp_q[0][31:0]));
      rx_rdy_i = 1'b1;
      wait_grant(n);
      check("bp_grant_wait", 64'(n), 64'(9));
      send_beats(2'd3, 8, 64'h0, 64'h0, 1'b0);
      drain();
      check_status();

      // Framing errors: start missing on beat 0, end early on beat 2
      send_pkt(2'd1, 4, 64'h1, 64'h4, 1, 1'b0);
      check_status();
      drain();
      err_clr_i = 1'b1;
      step();
      err_clr_i = 1'b0;
      exp_code = '0;
      check_status();

      // Illegal length 0, held
      fmt_req_i = 1'b1; fmt_chid_i = 2'd0; fmt_length_i = 6'd0;
      for (int i = 0; i < 5; i++) begin
         step();
         check("ill0_err", 64'(err_o), 64'(i == 0));
         check("ill0_grant", 64'(fmt_grant_o), 64'(0));
      end
      fmt_req_i = 1'b0;
      exp_code[2] = 1'b1;
      check_status();
      step();
      err_clr_i = 1'b1;
      step();
      err_clr_i = 1'b0;
      exp_code = '0;
      check_status();
      // Illegal length DEPTH+1 arriving together with a clear: the set wins
      fmt_req_i = 1'b1; fmt_length_i = 6'(DEPTH + 1); err_clr_i = 1'b1;
      step();
      err_clr_i = 1'b0;
      exp_code[2] = 1'b1;
      check("ill33_err", 64'(err_o), 64'(1));
      check_status();
      step();
      check("ill33_err_once", 64'(err_o), 64'(0));
      check("ill33_grant", 64'(fmt_grant_o), 64'(0));
      fmt_req_i = 1'b0;
      step();
      err_clr_i = 1'b1;
      step();
      err_clr_i = 1'b0;
      exp_code = '0;

      // Back-to-back channels
      for (int c = 0; c < 4; c++) begin
         g_prev = last_grant_cyc;
         send_pkt(2'(c), 8, 64'h0, 64'h0, 1, 1'b0);
         if (c > 0) check("grant_spacing", 64'(last_grant_cyc - g_prev), 64'(10));
      end
      drain();
      check_status();

      // Randomized packets with random consumer stalls
      rand_rdy = 1'b1;
      for (int i = 0; i < 6; i++)
         send_pkt(2'($urandom_range(0, 3)), int'($urandom_range(1, DEPTH)), 64'h0, 64'h0, -1, 1'b0);
      rand_rdy = 1'b0;
      rx_rdy_i = 1'b1;
      drain();
      check_status();

      // Length boundaries 1 and DEPTH
      send_pkt(2'd0, 1, 64'h0, 64'h0, 1, 1'b1);
      drain();
      send_pkt(2'd1, DEPTH, 64'h0, 64'h0, 1, 1'b0);
      drain();
      check_status();

      // Reset during beat 3 of a 16-word packet
      rx_rdy_i = 1'b0;
      fmt_req_i = 1'b1; fmt_chid_i = 2'd1; fmt_length_i = 6'd16;
      wait_grant(n);
      step();
      for (int k = 0; k < 4; k++) begin
         fmt_data_i = $urandom; fmt_start_i = (k == 0); fmt_end_i = 1'b0;
         if (k < 3) step();
      end
      check("pre_rst_val", 64'(rx_val_o), 64'(1));
      #2 rstn_i = 1'b0;
      #1;
      exp_q.delete();
      exp_cnt = '{default: '0};
      exp_code = '0;
      check("mid_rst_val", 64'(rx_val_o), 64'(0));
      check("mid_rst_data", 64'({rx_chid_o, rx_last_o, rx_data_o}), 64'(0));
      check("mid_rst_grant", 64'(fmt_grant_o), 64'(0));
      check("mid_rst_err", 64'(err_o), 64'(0));
      check_status();
      @(posedge clk_i); #1;
      rstn_i = 1'b1; fmt_start_i = 1'b0; fmt_data_i = '0;
      step();
      check("post_rst_empty", 64'(rx_val_o), 64'(0));
      rx_rdy_i = 1'b1;
      send_pkt(2'd3, 4, 64'h0, 64'h0, 1, 1'b1);
      drain();
      check_status();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
